// File: rtl/prog_rom.sv
// rtl/prog_rom.sv - loadable 16x8 instruction store with checksummed byte loader
// Ports:
//   CLK, RST             clock, synchronous active-low reset
//   PC                   fetch address; A/D = opcode/operand of mem[PC], combinational
//   ld_start             pulse: begin or restart a load (wins over a concurrent byte)
//   ld_valid/ld_data     loader byte stream; ld_ready = loader accepting
//   ld_count             program bytes accepted in the current load (0..16)
//   ld_err               last load failed its XOR checksum
//   cpu_rst_n            CPU datapath reset, released only in RUN
module prog_rom #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC,
  output logic [3:0]        A,
  output logic [3:0]        D,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err,
  output logic              cpu_rst_n
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] mem [DEPTH];
  logic [7:0] chk;
  logic [7:0] fetch;
  logic       xfer;

  assign fetch = mem[PC];
  assign A     = fetch[7:4];
  assign D     = fetch[3:0];
  assign xfer  = ld_valid & ld_ready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Outputs depend on registered state only, so cpu_rst_n is glitch-free
  // with respect to the loader inputs.
  always_comb begin
    state_n   = state;
    ld_ready  = 1'b0;
    cpu_rst_n = 1'b0;
    case (state)
      S_EMPTY: begin
        if (ld_start) state_n = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          state_n = S_LOAD;
        end else if (xfer && ld_count == LAST_CNT) begin
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          state_n = S_LOAD;
        end else if (xfer) begin
          state_n = (ld_data == chk) ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        cpu_rst_n = 1'b1;
        if (ld_start) state_n = S_LOAD;
      end
      S_ERR: begin
        if (ld_start) state_n = S_LOAD;
      end
      default: state_n = S_EMPTY;
    endcase
  end

  // ld_start is checked before any transfer so a restart discards the
  // concurrent byte without touching memory or the running checksum.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      ld_count <= '0;
      chk      <= 8'h00;
      ld_err   <= 1'b0;
    end else if (ld_start) begin
      ld_count <= '0;
      chk      <= 8'h00;
      ld_err   <= 1'b0;
    end else if (state == S_LOAD && xfer) begin
      mem[ld_count[ADDR_W-1:0]] <= ld_data;
      chk                       <= chk ^ ld_data;
      if (ld_count != FULL_CNT) begin
        ld_count <= ld_count + 1'b1;
      end
    end else if (state == S_CHECK && xfer && ld_data != chk) begin
      ld_err <= 1'b1;
    end
  end

endmodule
